// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and helpers for the weight-stationary tile.
//   state_e    : tile control states
//   acc_width  : default accumulator width for a given operand width / grid size
//   SYS_LANE   : lane slice of a flat vector, lane j at [j*w +: w]
`define SYS_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // Full-precision width of an N-term sum of DW x DW products.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one grid cell. Holds a stationary weight, forwards the
// activation east and the running partial sum south, one register each.
//   clk, reset    : clock, synchronous active-low reset
//   i_en          : global advance enable (low = hold)
//   i_signed      : operands are two's complement when high
//   i_w_load, i_w : weight register load strobe and value
//   i_act, o_act  : activation in from west / out to east
//   i_psum, o_psum: partial sum in from north / out to south
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_signed,
  input  logic          i_w_load,
  input  logic [DW-1:0] i_w,
  input  logic [DW-1:0] i_act,
  input  logic [AW-1:0] i_psum,
  output logic [DW-1:0] o_act,
  output logic [AW-1:0] o_psum
);

  logic [DW-1:0] r_w;
  logic [DW-1:0] r_act;
  logic [AW-1:0] r_psum;
  logic [AW-1:0] w_a_ext;
  logic [AW-1:0] w_w_ext;

  // Extending both operands to AW and keeping the low AW bits of the product
  // gives the correct modular result for signed and unsigned alike.
  assign w_a_ext = {{(AW-DW){i_signed & i_act[DW-1]}}, i_act};
  assign w_w_ext = {{(AW-DW){i_signed & r_w[DW-1]}}, r_w};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_w    <= '0;
      r_act  <= '0;
      r_psum <= '0;
    end else begin
      if (i_w_load) r_w <= i_w;
      if (i_en) begin
        r_act  <= i_act;
        r_psum <= i_psum + w_a_ext * w_w_ext;
      end
    end
  end

  assign o_act  = r_act;
  assign o_psum = r_psum;

endmodule

// File: rtl/systolic_tile.sv
// systolic_tile: N x N weight-stationary matrix-vector engine, y = a * W.
//   clk, reset            : clock, synchronous active-low reset
//   signed_mode           : operand signedness, captured with weight row 0
//   w_valid/w_ready/weights          : weight row stream, rows 0..N-1 in order
//   act_valid/act_ready/activations/act_last : activation vector stream
//   out_valid/out_ready/output_row/out_last  : result stream, lane j = y[j]
//   busy                  : high while loading weights or draining a batch
// Latency is 2N cycles from acceptance to out_valid; one vector per cycle.
module systolic_tile
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ARRAY_SIZE)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             signed_mode,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] weights,
  input  logic                             act_valid,
  output logic                             act_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] activations,
  input  logic                             act_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  output_row,
  output logic                             out_last,
  output logic                             busy
);

  localparam int N      = ARRAY_SIZE;
  localparam int DW     = DATA_WIDTH;
  localparam int AW     = ACC_WIDTH;
  localparam int STAGES = 2 * N;
  localparam int RW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  state_e        r_state, w_state_nxt;
  logic [RW-1:0] r_row;
  logic [RW-1:0] w_row_idx;
  logic          r_signed;
  logic [STAGES:0] r_vld;
  logic [STAGES:0] r_last;

  logic w_en;
  logic w_pipe_empty;
  logic w_w_fire;
  logic w_act_fire;

  // Whole datapath freezes only while a result is waiting on downstream.
  assign w_en         = !(r_vld[STAGES] && !out_ready);
  assign w_pipe_empty = ~|r_vld;
  assign w_w_fire     = w_valid && w_ready;
  assign w_act_fire   = act_valid && act_ready;

  assign out_valid = r_vld[STAGES];
  assign out_last  = r_last[STAGES];
  assign busy      = (r_state == S_LOAD) || (r_state == S_DRAIN);

  // ---------------------------------------------------------------- control
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    act_ready   = 1'b0;
    w_row_idx   = r_row;
    case (r_state)
      S_IDLE: begin
        w_ready   = 1'b1;
        w_row_idx = '0;
        if (w_valid) w_state_nxt = (LAST_ROW == '0) ? S_READY : S_LOAD;
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid && r_row == LAST_ROW) w_state_nxt = S_READY;
      end
      S_READY: begin
        // A pending activation blocks a weight reload in the same cycle.
        act_ready = w_en;
        w_ready   = w_pipe_empty && !act_valid;
        w_row_idx = '0;
        if (act_valid && w_en) begin
          if (act_last) w_state_nxt = S_DRAIN;
        end else if (w_pipe_empty && w_valid) begin
          w_state_nxt = (LAST_ROW == '0) ? S_READY : S_LOAD;
        end
      end
      S_DRAIN: begin
        if (r_vld[STAGES] && out_ready && r_last[STAGES]) w_state_nxt = S_READY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_signed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_w_fire) begin
        r_row <= w_row_idx + RW'(1);
        if (w_row_idx == '0) r_signed <= signed_mode;
      end
    end
  end

  // Valid/last travel with each wavefront; bubbles are simply zero bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld  <= '0;
      r_last <= '0;
    end else if (w_en) begin
      r_vld  <= {r_vld[STAGES-1:0], w_act_fire};
      r_last <= {r_last[STAGES-1:0], w_act_fire && act_last};
    end
  end

  // ---------------------------------------------------------------- input skew
  // Lane i passes through i+1 registers so row i sees its element i cycles
  // after row 0; the first register is the capture stage for all lanes.
  logic [N-1:0][DW-1:0] w_skew_act;

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] r_dly [0:i];
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int k = 0; k <= i; k++) r_dly[k] <= '0;
      end else if (w_en) begin
        r_dly[0] <= `SYS_LANE(activations, i, DW);
        for (int k = 1; k <= i; k++) r_dly[k] <= r_dly[k-1];
      end
    end
    assign w_skew_act[i] = r_dly[i];
  end

  // ---------------------------------------------------------------- PE grid
  logic [N-1:0][N-1:0][DW-1:0] w_act_q;
  logic [N-1:0][N-1:0][AW-1:0] w_psum_q;
  logic [N-1:0][DW-1:0]        w_east_unused;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] w_a_in;
      logic [AW-1:0] w_p_in;

      if (j == 0) begin : g_west
        assign w_a_in = w_skew_act[i];
      end else begin : g_link
        assign w_a_in = w_act_q[i][j-1];
      end

      if (i == 0) begin : g_top
        assign w_p_in = '0;
      end else begin : g_acc
        assign w_p_in = w_psum_q[i-1][j];
      end

      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_en),
        .i_signed (r_signed),
        .i_w_load (w_w_fire && (w_row_idx == RW'(i))),
        .i_w      (`SYS_LANE(weights, j, DW)),
        .i_act    (w_a_in),
        .i_psum   (w_p_in),
        .o_act    (w_act_q[i][j]),
        .o_psum   (w_psum_q[i][j])
      );
    end
    assign w_east_unused[i] = w_act_q[i][N-1];
  end

  // ---------------------------------------------------------------- de-skew
  // Column j finishes j cycles after column 0; N-j registers (the last one
  // being the output register) line every lane up on the same beat.
  logic [N-1:0][AW-1:0] w_row_out;

  for (genvar j = 0; j < N; j++) begin : g_dsk
    logic [AW-1:0] r_dly [0:N-1-j];
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int k = 0; k <= N - 1 - j; k++) r_dly[k] <= '0;
      end else if (w_en) begin
        r_dly[0] <= w_psum_q[N-1][j];
        for (int k = 1; k <= N - 1 - j; k++) r_dly[k] <= r_dly[k-1];
      end
    end
    assign w_row_out[j] = r_dly[N-1-j];
  end

  assign output_row = w_row_out;

endmodule

// File: tb/tb_systolic_tile.sv
module tb_systolic_tile;

  localparam int N  = 8;
  localparam int DW = 4;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed_mode = 1'b0;
  logic w_valid = 1'b0;
  logic act_valid = 1'b0;
  logic act_last = 1'b0;
  logic out_ready = 1'b1;
  logic [N*DW-1:0] weights = '0;
  logic [N*DW-1:0] activations = '0;
  logic w_ready, act_ready, out_valid, out_last, busy;
  logic [N*AW-1:0] output_row;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef logic [N-1:0][N*DW-1:0] wmat_t;
  typedef struct {
    logic [N*AW-1:0] row;
    logic            last;
    int              due;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  systolic_tile #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .signed_mode (signed_mode),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .weights     (weights),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .activations (activations),
    .act_last    (act_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_row  (output_row),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference math: y[j] = sum_i a[i]*W[i][j] mod 2^AW.
  function automatic logic [N*AW-1:0] model(input logic [N*DW-1:0] a, input wmat_t m, input logic sgn);
    logic [N*AW-1:0] y;
    int s, av, wv;
    y = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        av = int'(a[i*DW +: DW]);
        wv = int'(m[i][j*DW +: DW]);
        if (sgn && av >= 8) av -= 16;
        if (sgn && wv >= 8) wv -= 16;
        s += av * wv;
      end
      y[j*AW +: AW] = s[AW-1:0];
    end
    return y;
  endfunction

  // Scoreboard monitor: compares each accepted result beat in order.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", output_row);
      end else begin
        e = sb.pop_front();
        check("out_row", output_row, e.row);
        check("out_last", out_last, e.last);
        if (e.due >= 0) check("latency", cyc, e.due);
      end
    end
  end

  // All driver tasks start and finish at posedge+1.
  task automatic send_w(input logic [N*DW-1:0] row, input logic sgn);
    int k;
    k = 0;
    w_valid = 1'b1; weights = row; signed_mode = sgn;
    @(negedge clk);
    while (!w_ready && k < 200) begin @(negedge clk); k++; end
    if (!w_ready) begin
      n_tests++; n_fail++;
      $display("FAIL w_handshake: got timeout expected w_ready");
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic load_w(input wmat_t m, input logic sgn);
    for (int i = 0; i < N; i++) send_w(m[i], sgn);
  endtask

  task automatic send_a(input logic [N*DW-1:0] a, input logic last,
                        input logic [N*AW-1:0] exp, input logic lat);
    int k;
    exp_t x;
    k = 0;
    act_valid = 1'b1; activations = a; act_last = last;
    @(negedge clk);
    while (!act_ready && k < 200) begin @(negedge clk); k++; end
    if (!act_ready) begin
      n_tests++; n_fail++;
      $display("FAIL act_handshake: got timeout expected act_ready");
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      x.row = exp; x.last = last; x.due = lat ? cyc + 2 * N : -1;
      sb.push_back(x);
    end
    act_valid = 1'b0; act_last = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 400) begin @(negedge clk); k++; end
    check("drain_done", (sb.size() == 0 && !busy), 1);
    check("ready_after_drain", act_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    wmat_t w_id, w_f, w_s, w_anti, w_x3;
    logic [N*DW-1:0] av, av2;
    logic [N*AW-1:0] ex;
    exp_t x;
    int k;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_output_row", output_row, 0);
    check("rst_busy", busy, 0);
    check("rst_act_ready", act_ready, 0);
    check("rst_w_ready", w_ready, 1);
    @(posedge clk); #1;

    // Identity, unsigned, exact latency
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        w_id[i][j*DW +: DW]   = (i == j) ? 4'd1 : 4'd0;
        w_f[i][j*DW +: DW]    = 4'hF;
        w_s[i][j*DW +: DW]    = 4'((3 * i + 5 * j) & 15);
        w_anti[i][j*DW +: DW] = (i == N - 1 - j) ? 4'd2 : 4'd0;
        w_x3[i][j*DW +: DW]   = (i == j) ? 4'd3 : 4'd0;
      end
    load_w(w_id, 1'b0);
    check("loaded_busy", busy, 0);
    check("loaded_act_ready", act_ready, 1);
    for (int i = 0; i < N; i++) av[i*DW +: DW] = 4'(i + 1);
    for (int j = 0; j < N; j++) ex[j*AW +: AW] = 11'(j + 1);
    send_a(av, 1'b1, ex, 1'b1);
    wait_drain();

    // Sign mode: all weights 4'hF, activations all 2
    av = {N{4'd2}};
    load_w(w_f, 1'b1);
    send_a(av, 1'b1, {N{11'h7F0}}, 1'b1);
    wait_drain();
    load_w(w_f, 1'b0);
    send_a(av, 1'b1, {N{11'd240}}, 1'b1);
    wait_drain();

    // Streaming: 20 back-to-back vectors, last on the 20th
    load_w(w_s, 1'b1);
    for (int v = 0; v < 20; v++) begin
      for (int i = 0; i < N; i++) av[i*DW +: DW] = 4'((7 * v + 3 * i + 1) & 15);
      send_a(av, (v == 19), model(av, w_s, 1'b1), 1'b1);
    end
    wait_drain();

    // Backpressure: out_ready low for 5 cycles mid-stream
    fork
      begin
        for (int v = 0; v < 12; v++) begin
          for (int i = 0; i < N; i++) av2[i*DW +: DW] = 4'((5 * v + 9 * i + 2) & 15);
          send_a(av2, (v == 11), model(av2, w_s, 1'b1), 1'b0);
        end
      end
      begin
        k = 0;
        while (!out_valid && k < 200) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_out_valid", out_valid, 1);
          check("stall_act_ready", act_ready, 0);
          if (sb.size() > 0) check("stall_row", output_row, sb[0].row);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-batch after 3 accepted vectors
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < N; i++) av[i*DW +: DW] = 4'(v + i);
      send_a(av, 1'b0, model(av, w_s, 1'b1), 1'b0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_w_ready", w_ready, 1);
    check("mid_rst_act_ready", act_ready, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) av[i*DW +: DW] = 4'(i + 1);
    act_valid = 1'b1; activations = av; act_last = 1'b1;
    for (int r = 0; r < N - 1; r++) begin
      send_w(w_anti[r], 1'b0);
      check("act_blocked_in_load", act_ready, 0);
    end
    act_valid = 1'b0; act_last = 1'b0;
    send_w(w_anti[N-1], 1'b0);
    check("reload_act_ready", act_ready, 1);
    // y[j] = 2*a[N-1-j] with a = 1..8
    for (int j = 0; j < N; j++) ex[j*AW +: AW] = 11'(2 * (N - j));
    send_a(av, 1'b1, ex, 1'b1);
    wait_drain();

    // Contention: activation wins, weights unchanged
    for (int i = 0; i < N; i++) av[i*DW +: DW] = 4'(N - i);
    act_valid = 1'b1; activations = av; act_last = 1'b1;
    w_valid = 1'b1; weights = {N{4'hF}};
    @(negedge clk);
    check("contend_w_ready", w_ready, 0);
    check("contend_act_ready", act_ready, 1);
    @(posedge clk); #1;
    // y[j] = 2*a[N-1-j] with a = 8..1 gives 2,4,...,16
    for (int j = 0; j < N; j++) ex[j*AW +: AW] = 11'(2 * (j + 1));
    x.row = ex; x.last = 1'b1; x.due = cyc + 2 * N;
    sb.push_back(x);
    act_valid = 1'b0; act_last = 1'b0; w_valid = 1'b0;
    wait_drain();

    // Reload with a new W: results from the new weights only
    load_w(w_x3, 1'b0);
    for (int j = 0; j < N; j++) ex[j*AW +: AW] = 11'(3 * (N - j));
    send_a(av, 1'b1, ex, 1'b1);
    wait_drain();

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
